// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage. Owns the PC, drives the instruction-memory read
// address combinationally from the PC, and captures the returned word into the
// IF/ID pipeline register. Decode consumes that register over a valid/ready
// handshake. Taken branches/jumps from execute redirect the PC and flush the
// wrong-path instruction. A misaligned redirect target parks the stage in a
// fault state until reset.
//
// Ports
//   clk_i          in   clock, rising edge
//   rst_ni         in   asynchronous reset, active low
//   imem_addr_o    out  [31:0] instruction-memory byte address (= PC)
//   imem_instr_i   in   [31:0] instruction word for imem_addr_o
//   redirect_i     in   execute requests a PC change
//   redirect_pc_i  in   [31:0] redirect target byte address
//   id_valid_o     out  IF/ID register holds a valid instruction
//   id_ready_i     in   decode accepts IF/ID contents this cycle
//   id_instr_o     out  [31:0] fetched instruction (NOP_INSTR when not valid)
//   id_pc_o        out  [31:0] PC of id_instr_o
//   id_pc4_o       out  [31:0] id_pc_o + 4, modulo 2^32
//   misaligned_o   out  sticky flag: a redirect target was not word aligned
//   fetch_count_o  out  [31:0] completed IF->ID transfers, wrapping
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic        misaligned_o,
  output logic [31:0] fetch_count_o
);

  // BOOT gives memory one cycle to settle before the first fetch.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic        id_valid_r;
  logic [31:0] id_instr_r;
  logic [31:0] id_pc_r;
  logic        misaligned_r;
  logic [31:0] fetch_count_r;

  logic        xfer_s;
  logic        redir_s;
  logic        redir_misaligned_s;
  logic        fetch_en_s;

  // Handshake, redirect and fetch-enable decode.
  always_comb begin
    xfer_s             = 1'b0;
    redir_s            = 1'b0;
    redir_misaligned_s = 1'b0;
    fetch_en_s         = 1'b0;
    xfer_s  = id_valid_r & id_ready_i;
    if (state_r == ST_RUN) begin
      redir_s            = redirect_i;
      redir_misaligned_s = redirect_i & (redirect_pc_i[1:0] != 2'b00);
      // Fetch only into an empty slot or one being drained this cycle;
      // a redirect suppresses the fetch so the wrong-path word is never captured.
      fetch_en_s         = ~redirect_i & (~id_valid_r | id_ready_i);
    end else begin
      redir_s            = 1'b0;
      redir_misaligned_s = 1'b0;
      fetch_en_s         = 1'b0;
    end
  end

  // PC, FSM, IF/ID register, sticky fault flag and transfer counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_PC;
      id_valid_r    <= 1'b0;
      id_instr_r    <= NOP_INSTR;
      id_pc_r       <= 32'h0000_0000;
      misaligned_r  <= 1'b0;
      fetch_count_r <= 32'h0000_0000;
    end else begin
      // A transfer completing alongside a redirect still counts: decode took it.
      if (xfer_s) begin
        fetch_count_r <= fetch_count_r + 32'd1;
      end

      if (redir_s) begin
        id_valid_r <= 1'b0;
        id_instr_r <= NOP_INSTR;
        pc_r       <= redirect_pc_i;
        if (redir_misaligned_s) begin
          misaligned_r <= 1'b1;
          state_r      <= ST_FAULT;
        end
      end else if (fetch_en_s) begin
        id_valid_r <= 1'b1;
        id_instr_r <= imem_instr_i;
        id_pc_r    <= pc_r;
        pc_r       <= pc_r + 32'd4;
      end else if (xfer_s) begin
        // Drained with nothing to refill (BOOT/FAULT): slot goes empty.
        id_valid_r <= 1'b0;
        id_instr_r <= NOP_INSTR;
      end

      case (state_r)
        ST_BOOT:  state_r <= ST_RUN;
        ST_RUN:   ; // RUN -> FAULT handled with the redirect above
        ST_FAULT: state_r <= ST_FAULT;
        default:  state_r <= ST_FAULT;
      endcase
    end
  end

  assign imem_addr_o   = pc_r;
  assign id_valid_o    = id_valid_r;
  assign id_instr_o    = id_instr_r;
  assign id_pc_o       = id_pc_r;
  assign id_pc4_o      = id_pc_r + 32'd4;
  assign misaligned_o  = misaligned_r;
  assign fetch_count_o = fetch_count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed, table-driven bench for fetch_stage. Instruction memory is a simple
// address-derived pattern so every expected word is known from its PC.
// A second instance with RESET_PC = 32'hFFFF_FFFC covers PC wrap-around and
// asynchronous reset while stalled.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        misaligned;
  logic [31:0] fetch_count;

  logic        rst_w;
  logic [31:0] imem_addr_w;
  logic [31:0] imem_instr_w;
  logic        redirect_w;
  logic [31:0] redirect_pc_w;
  logic        id_valid_w;
  logic        id_ready_w;
  logic [31:0] id_instr_w;
  logic [31:0] id_pc_w;
  logic [31:0] id_pc4_w;
  logic        misaligned_w;
  logic [31:0] fetch_count_w;

  int n_checks = 0;
  int n_fails  = 0;

  // Instruction memory contents: a fixed pattern of the address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign imem_instr   = imem_word(imem_addr);
  assign imem_instr_w = imem_word(imem_addr_w);

  fetch_stage dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .id_valid_o(id_valid), .id_ready_i(id_ready),
    .id_instr_o(id_instr), .id_pc_o(id_pc), .id_pc4_o(id_pc4),
    .misaligned_o(misaligned), .fetch_count_o(fetch_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk_i(clk), .rst_ni(rst_w),
    .imem_addr_o(imem_addr_w), .imem_instr_i(imem_instr_w),
    .redirect_i(redirect_w), .redirect_pc_i(redirect_pc_w),
    .id_valid_o(id_valid_w), .id_ready_i(id_ready_w),
    .id_instr_o(id_instr_w), .id_pc_o(id_pc_w), .id_pc4_o(id_pc4_w),
    .misaligned_o(misaligned_w), .fetch_count_o(fetch_count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        red;
    logic [31:0] rpc;
    logic        ev;      // expected id_valid
    logic [31:0] epc;     // expected id_pc
    logic [31:0] eaddr;   // expected imem_addr
    logic        emis;    // expected misaligned
    logic [31:0] ecnt;    // expected fetch_count
  } vec_t;

  vec_t vecs[13];

  task automatic check_main(input string tag, input logic ev, input logic [31:0] epc,
                            input logic [31:0] eaddr, input logic emis, input logic [31:0] ecnt);
    chk({tag, " id_valid"}, {31'd0, id_valid}, {31'd0, ev});
    chk({tag, " id_pc"}, id_pc, epc);
    chk({tag, " id_pc4"}, id_pc4, epc + 32'd4);
    chk({tag, " id_instr"}, id_instr, ev ? imem_word(epc) : NOP);
    chk({tag, " imem_addr"}, imem_addr, eaddr);
    chk({tag, " misaligned"}, {31'd0, misaligned}, {31'd0, emis});
    chk({tag, " fetch_count"}, fetch_count, ecnt);
  endtask

  initial begin
    //            rdy   red   rpc            ev    epc            eaddr          mis   cnt
    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'd0}; // BOOT->RUN
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0004, 1'b0, 32'd0}; // first fetch
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0004, 32'h0000_0008, 1'b0, 32'd1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0004, 32'h0000_0008, 1'b0, 32'd1}; // stall
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0004, 32'h0000_0008, 1'b0, 32'd1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0004, 32'h0000_0008, 1'b0, 32'd1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008, 32'h0000_000C, 1'b0, 32'd2}; // release
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_0008, 32'h0000_0020, 1'b0, 32'd3}; // redirect
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0020, 32'h0000_0024, 1'b0, 32'd3};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0024, 32'h0000_0028, 1'b0, 32'd4};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_0022, 1'b0, 32'h0000_0024, 32'h0000_0022, 1'b1, 32'd5}; // misaligned
    vecs[11] = '{1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_0024, 32'h0000_0022, 1'b1, 32'd5}; // ignored
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0024, 32'h0000_0022, 1'b1, 32'd5};

    rst_n = 1'b0; id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0000_0000;
    rst_w = 1'b0; id_ready_w = 1'b0; redirect_w = 1'b0; redirect_pc_w = 32'h0000_0000;

    // Reset state, checked between clock edges.
    #12;
    check_main("reset", 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'd0);
    rst_n = 1'b1;

    // Main table: drive, clock, then sample 1 time unit after the edge.
    for (int i = 0; i < 13; i++) begin
      id_ready    = vecs[i].rdy;
      redirect    = vecs[i].red;
      redirect_pc = vecs[i].rpc;
      @(posedge clk); #1;
      check_main($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].eaddr,
                 vecs[i].emis, vecs[i].ecnt);
    end

    // Reset pulse out of FAULT: flag cleared, fetch restarts at 0.
    id_ready = 1'b1; redirect = 1'b0;
    rst_n = 1'b0; #1;
    chk("fault reset misaligned", {31'd0, misaligned}, 32'd0);
    chk("fault reset count", fetch_count, 32'd0);
    chk("fault reset addr", imem_addr, 32'h0000_0000);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart boot valid", {31'd0, id_valid}, 32'd0);
    @(posedge clk); #1;
    chk("restart valid", {31'd0, id_valid}, 32'd1);
    chk("restart pc", id_pc, 32'h0000_0000);
    chk("restart instr", id_instr, imem_word(32'h0000_0000));

    // Wrap-around instance.
    rst_w = 1'b1;
    @(posedge clk); #1;
    chk("wrap boot valid", {31'd0, id_valid_w}, 32'd0);
    chk("wrap boot addr", imem_addr_w, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap first valid", {31'd0, id_valid_w}, 32'd1);
    chk("wrap first pc", id_pc_w, 32'hFFFF_FFFC);
    chk("wrap first pc4", id_pc4_w, 32'h0000_0000);
    chk("wrap first instr", id_instr_w, imem_word(32'hFFFF_FFFC));
    chk("wrap pc wrapped", imem_addr_w, 32'h0000_0000);
    id_ready_w = 1'b1;
    @(posedge clk); #1;
    chk("wrap second pc", id_pc_w, 32'h0000_0000);
    chk("wrap second pc4", id_pc4_w, 32'h0000_0004);
    chk("wrap second instr", id_instr_w, imem_word(32'h0000_0000));
    chk("wrap count", fetch_count_w, 32'd1);
    id_ready_w = 1'b0;
    @(posedge clk); #1;
    chk("wrap stall valid", {31'd0, id_valid_w}, 32'd1);
    chk("wrap stall pc", id_pc_w, 32'h0000_0000);
    // Asynchronous reset mid-stall, observed before the next clock edge.
    #3 rst_w = 1'b0;
    #1;
    chk("async reset valid", {31'd0, id_valid_w}, 32'd0);
    chk("async reset instr", id_instr_w, NOP);
    chk("async reset addr", imem_addr_w, 32'hFFFF_FFFC);
    chk("async reset count", fetch_count_w, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule
